serial_add_sequencer: RTL

//  Bit-serial add/subtract controller: time-shares one full-adder cell (two

---
 rtl/serial_add_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer: one full-adder cell time-shared over
// WIDTH bits, LSB first, with a Start/Done handshake.
//
// Ports:
//   Clk, Reset      clock, async active-high reset
//   Start           request, sampled only while idle
//   Sub             0: A+B, 1: A-B (captured with Start)
//   A, B            operands (captured with Start)
//   Busy            high while an operation is in flight
//   Done            one-cycle result-valid pulse
//   Sum             result, held until the next completion
//   CarryOut        carry out of MSB (subtract: 1 = no borrow)
//   Overflow        signed overflow

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  // Holds the WIDTH-1 low result bits; the MSB joins them at completion.
  logic [WIDTH-2:0] shs;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic p;
  logic g0;
  logic s;
  logic g1;
  logic c;

  half_adder u_ha0 (
    .a (sha[0]),
    .b (shb[0]),
    .s (p),
    .c (g0)
  );

  half_adder u_ha1 (
    .a (p),
    .b (cy),
    .s (s),
    .c (g1)
  );

  assign c = g0 | g1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      sha      <= '0;
      shb      <= '0;
      shs      <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            // Subtract as A + ~B + 1: the +1 is the initial carry.
            sha   <= A;
            shb   <= Sub ? ~B : B;
            cy    <= Sub;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sha <= sha >> 1;
          shb <= shb >> 1;
          shs <= (WIDTH-1)'({s, shs} >> 1);
          cy  <= c;
          if (cnt == LAST) begin
            // cy is the carry into the MSB at this edge.
            Sum      <= {s, shs};
            CarryOut <= c;
            Overflow <= c ^ cy;
            Done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
